// File: rtl/fifo_pkg.sv
// Shared types for the synchronous threshold FIFO.
package fifo_pkg;

  // Read-side behaviour of the FIFO.
  //   FIFO_STD  : data_out is a register loaded by an accepted read.
  //   FIFO_FWFT : data_out shows the head entry combinationally.
  typedef enum logic [0:0] {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one
// asynchronous read port, contents never reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word at the write address when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with programmable almost-full / almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and
// a choice of registered or first-word-fall-through read data.
module sync_fifo_thresh
  import fifo_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         DEPTH    = 16,
  parameter fifo_mode_e MODE     = FIFO_STD,
  parameter int         AF_LEVEL = DEPTH - 2,
  parameter int         AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);

  // Reject illegal parameterisations at elaboration time.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_thresh: DEPTH must be a power of two >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_thresh: WIDTH must be >= 1");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_thresh: AF_LEVEL must be in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_thresh: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Handshake: a write is accepted when wr_en=1, full=0 and flush=0 at the
  // rising edge; a read is accepted when rd_en=1, empty=0 and flush=0.
  // Requests that are not accepted are dropped (never queued), and a
  // request against full/empty marks the matching sticky error flag.
  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Next-state for pointers, occupancy and sticky flags; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (wr_en && full)  ovf_d = 1'b1;
      if (rd_en && empty) unf_d = 1'b1;
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    // Load the head entry on an accepted read, otherwise hold.
    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = ram_rdata;
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) dout_q <= '0;
      else         dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    // Head entry falls through; meaningless while empty.
    assign data_out = ram_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh: one registered-read instance and
// one first-word-fall-through instance driven by the same stimulus.
module tb_sync_fifo_thresh;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       flush;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_level, f_level;

  int test_cnt = 0;
  int fail_cnt = 0;
  logic [7:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  sync_fifo_thresh #(
    .WIDTH(8), .DEPTH(16), .MODE(FIFO_STD), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut_std (
    .clk(clk), .arst_n(arst_n), .flush(flush), .wr_en(wr_en),
    .data_in(data_in), .rd_en(rd_en), .data_out(s_dout), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .level(s_level), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_thresh #(
    .WIDTH(8), .DEPTH(16), .MODE(FIFO_FWFT), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut_fw (
    .clk(clk), .arst_n(arst_n), .flush(flush), .wr_en(wr_en),
    .data_in(data_in), .rd_en(rd_en), .data_out(f_dout), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .level(f_level), .overflow(f_ovf), .underflow(f_unf)
  );

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of requests, sample 1 time unit after the edge
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_flush(input logic w, input logic [7:0] d);
    flush   = 1'b1;
    wr_en   = w;
    data_in = d;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_level"}, 32'(s_level), 32'd0);
    chk({tag, "_empty"}, 32'(s_empty), 32'd1);
    chk({tag, "_full"},  32'(s_full),  32'd0);
    chk({tag, "_af"},    32'(s_af),    32'd0);
    chk({tag, "_ae"},    32'(s_ae),    32'd1);
    chk({tag, "_ovf"},   32'(s_ovf),   32'd0);
    chk({tag, "_unf"},   32'(s_unf),   32'd0);
    chk({tag, "_dout"},  32'(s_dout),  32'h00);
    chk({tag, "_fw_empty"}, 32'(f_empty), 32'd1);
  endtask

  initial begin
    arst_n  = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    #3;
    chk_reset_values("rst");
    #10;
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, watching thresholds after every edge
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_level", 32'(s_level), 32'(i + 1));
      chk("fill_full",  32'(s_full),  32'((i + 1) == 16));
      chk("fill_af",    32'(s_af),    32'((i + 1) >= 14));
      chk("fill_ae",    32'(s_ae),    32'((i + 1) <= 2));
    end
    chk("fill_fw_head", 32'(f_dout), 32'h00);
    chk("fill_ovf0", 32'(s_ovf), 32'd0);

    // 17th write is dropped and marks overflow
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_level", 32'(s_level), 32'd16);
    chk("ovf_flag",  32'(s_ovf),   32'd1);
    chk("ovf_fw_flag", 32'(f_ovf), 32'd1);

    // Write+read while full: write dropped, read accepted
    step(1'b1, 8'hEE, 1'b1);
    chk("fullrw_level", 32'(s_level), 32'd15);
    chk("fullrw_dout",  32'(s_dout),  32'h00);
    chk("fullrw_fw",    32'(f_dout),  32'h01);

    // Drain down to level 7
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain7_dout",  32'(s_dout),  32'(k));
      chk("drain7_level", 32'(s_level), 32'(15 - k));
    end

    // Flush at level 7 with a write request
    do_flush(1'b1, 8'h77);
    chk("flush_level", 32'(s_level), 32'd0);
    chk("flush_empty", 32'(s_empty), 32'd1);
    chk("flush_ovf",   32'(s_ovf),   32'd0);
    chk("flush_unf",   32'(s_unf),   32'd0);
    chk("flush_hold",  32'(s_dout),  32'h08);

    // Read from empty sets underflow; flush clears it
    step(1'b0, 8'h00, 1'b1);
    chk("unf_flag",  32'(s_unf),   32'd1);
    chk("unf_level", 32'(s_level), 32'd0);
    do_flush(1'b0, 8'h00);
    chk("unf_clear", 32'(s_unf), 32'd0);

    // Streaming 20 words through with continuous reads (pointer wrap)
    exp_q.push_back(8'h00);
    step(1'b1, 8'h00, 1'b0);
    chk("wrap_fw_first", 32'(f_dout),  32'h00);
    chk("wrap_fw_empty", 32'(f_empty), 32'd0);
    for (int k = 1; k < 20; k++) begin
      exp_q.push_back(8'(k));
      step(1'b1, 8'(k), 1'b1);
      chk("wrap_dout",  32'(s_dout),  32'(exp_q.pop_front()));
      chk("wrap_fw",    32'(f_dout),  32'(k));
      chk("wrap_level", 32'(s_level), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("wrap_last",  32'(s_dout),  32'(exp_q.pop_front()));
    chk("wrap_empty", 32'(s_empty), 32'd1);
    chk("wrap_unf",   32'(s_unf),   32'd0);
    chk("wrap_sb",    32'(exp_q.size()), 32'd0);

    // FWFT: write into empty appears next cycle, read empties it
    step(1'b1, 8'hA5, 1'b0);
    chk("fwft_dout",  32'(f_dout),  32'hA5);
    chk("fwft_empty", 32'(f_empty), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_rd_empty", 32'(f_empty), 32'd1);
    chk("fwft_std_dout", 32'(s_dout),  32'hA5);

    // Level 5 with simultaneous write and read
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h10 + k), 1'b0);
    chk("l5_level", 32'(s_level), 32'd5);
    step(1'b1, 8'h30, 1'b1);
    chk("l5rw_level", 32'(s_level), 32'd5);
    chk("l5rw_dout",  32'(s_dout),  32'h10);
    chk("l5rw_fw",    32'(f_dout),  32'h11);

    // Almost-empty threshold crossing 3 -> 2
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("ae_l3_level", 32'(s_level), 32'd3);
    chk("ae_l3_flag",  32'(s_ae),    32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("ae_l2_flag",  32'(s_ae),    32'd1);
    chk("ae_l2_dout",  32'(s_dout),  32'h13);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("l5_final_dout", 32'(s_dout), 32'h30);
    chk("l5_final_empty", 32'(s_empty), 32'd1);

    // Asynchronous reset in the middle of a write burst
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    chk("burst_level", 32'(s_level), 32'd3);
    wr_en   = 1'b1;
    data_in = 8'h43;
    #2;
    arst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    wr_en = 1'b0;
    #3;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h55, 1'b0);
    chk("post_rst_fw",    32'(f_dout),  32'h55);
    chk("post_rst_level", 32'(s_level), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_dout",  32'(s_dout),  32'h55);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
